// File: rtl/issue_ctrl_if.sv
// Bundle of decode, scoreboard and execute signals around the dual-issue stage.
// master = environment (decode/scoreboard/execute), slave = issue_ctrl.
interface issue_ctrl_if #(
  parameter int AW    = 5,
  parameter int POS_W = 8,
  parameter int LW    = $clog2(POS_W)
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_slot_v;
  logic [3:0][AW-1:0]      in_src;
  logic [1:0][AW-1:0]      in_dst;
  logic [1:0]              in_dst_wen;
  logic [1:0][LW-1:0]      in_lat;
  logic [3:0][AW-1:0]      sb_rd_addr;
  logic [3:0][POS_W-1:0]   sb_rd_pos;
  logic [1:0]              sb_wr_ena;
  logic [1:0][AW-1:0]      sb_wr_addr;
  logic [1:0][POS_W-1:0]   sb_wr_pos;
  logic [1:0]              iss_valid;
  logic                    iss_ready;
  logic [3:0][AW-1:0]      iss_src;
  logic [1:0][AW-1:0]      iss_dst;
  logic [3:0]              iss_fwd;

  modport master (
    output flush, in_valid, in_slot_v, in_src, in_dst, in_dst_wen, in_lat,
    output sb_rd_pos, iss_ready,
    input  in_ready, sb_rd_addr, sb_wr_ena, sb_wr_addr, sb_wr_pos,
    input  iss_valid, iss_src, iss_dst, iss_fwd
  );

  modport slave (
    input  flush, in_valid, in_slot_v, in_src, in_dst, in_dst_wen, in_lat,
    input  sb_rd_pos, iss_ready,
    output in_ready, sb_rd_addr, sb_wr_ena, sb_wr_addr, sb_wr_pos,
    output iss_valid, iss_src, iss_dst, iss_fwd
  );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue in-order issue stage: buffers one decoded pair, checks operands
// against scoreboard position vectors, issues slot 0 then slot 1, and writes
// result timing back to the scoreboard for every issued slot.
module issue_ctrl #(
  parameter int AW        = 5,
  parameter int POS_W     = 8,
  parameter int FWD_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  issue_ctrl_if.slave bus
);
  localparam int LW = $clog2(POS_W);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, HALF = 2'd2} state_t;

  state_t             state_reg, state_next;
  logic               v1_reg;
  logic [3:0][AW-1:0] src_reg;
  logic [1:0][AW-1:0] dst_reg;
  logic [1:0]         wen_reg;
  logic [1:0][LW-1:0] lat_reg;

  logic [3:0] rdy;
  logic [3:0] pos_nz;
  logic       hold0, hold1, go, raw, waw;
  logic [1:0] iss;
  logic       in_ready_c, load;

  // Per-operand readiness: r0 is always ready, others once the result is
  // close enough to be caught on the bypass network.
  for (genvar gi = 0; gi < 4; gi++) begin : g_opnd
    assign rdy[gi]    = (src_reg[gi] == '0) || ((bus.sb_rd_pos[gi] >> FWD_DEPTH) == '0);
    assign pos_nz[gi] = (src_reg[gi] != '0) && (bus.sb_rd_pos[gi] != '0);
  end

  assign hold0 = (state_reg == FULL);
  assign hold1 = (state_reg == HALF) || ((state_reg == FULL) && v1_reg);
  assign go    = bus.iss_ready && !bus.flush;

  // Intra-pair hazards only matter when both slots try to go together.
  assign raw = wen_reg[0] && (dst_reg[0] != '0) &&
               ((src_reg[2] == dst_reg[0]) || (src_reg[3] == dst_reg[0]));
  assign waw = wen_reg[0] && wen_reg[1] && (dst_reg[0] != '0) && (dst_reg[0] == dst_reg[1]);

  assign iss[0] = hold0 && rdy[0] && rdy[1] && go;
  assign iss[1] = hold1 && rdy[2] && rdy[3] && go &&
                  ((state_reg == HALF) || (iss[0] && !raw && !waw));

  assign in_ready_c = !bus.flush &&
                      ((state_reg == EMPTY) || ((!hold0 || iss[0]) && (!hold1 || iss[1])));
  // A pair without a valid slot 0 carries nothing and is dropped.
  assign load = bus.in_valid && in_ready_c && bus.in_slot_v[0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Next-state logic: flush wins, then a new pair, then issue progress.
  always_comb begin
    state_next = state_reg;
    if (bus.flush)                                  state_next = EMPTY;
    else if (load)                                  state_next = FULL;
    else if (state_reg == FULL && iss[0])           state_next = (hold1 && !iss[1]) ? HALF : EMPTY;
    else if (state_reg == HALF && iss[1])           state_next = EMPTY;
  end

  // Output logic: issue strobes, scoreboard writes, bypass selects, ready.
  always_comb begin
    bus.iss_valid  = iss;
    bus.in_ready   = in_ready_c;
    bus.sb_wr_ena  = '0;
    bus.sb_wr_addr = '0;
    bus.sb_wr_pos  = '0;
    bus.iss_fwd    = '0;
    for (int i = 0; i < 2; i++) begin
      if (iss[i]) begin
        bus.sb_wr_ena[i]    = wen_reg[i] && (dst_reg[i] != '0);
        bus.sb_wr_addr[i]   = dst_reg[i];
        bus.sb_wr_pos[i]    = POS_W'(1) << lat_reg[i];
        bus.iss_fwd[2*i]    = pos_nz[2*i];
        bus.iss_fwd[2*i+1]  = pos_nz[2*i+1];
      end
    end
  end

  assign bus.sb_rd_addr = src_reg;
  assign bus.iss_src    = src_reg;
  assign bus.iss_dst    = dst_reg;

  // Instruction buffer: captured on accept; slot1 valid dropped once empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg  <= 1'b0;
      src_reg <= '0;
      dst_reg <= '0;
      wen_reg <= '0;
      lat_reg <= '0;
    end else if (load) begin
      v1_reg  <= bus.in_slot_v[1];
      src_reg <= bus.in_src;
      dst_reg <= bus.in_dst;
      wen_reg <= bus.in_dst_wen;
      lat_reg <= bus.in_lat;
    end else if (state_next == EMPTY) begin
      v1_reg  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios followed by random
// traffic, all checked against a queue-based model of pending instructions.
module tb_issue_ctrl;
  logic clk;
  logic rst_n;

  issue_ctrl_if #(.AW(5), .POS_W(8)) ifc ();

  issue_ctrl #(.AW(5), .POS_W(8), .FWD_DEPTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard contents as seen by the stage, indexed by register.
  logic [7:0] sb_pos_mem [32];
  always_comb begin
    ifc.sb_rd_pos = '0;
    for (int j = 0; j < 4; j++) ifc.sb_rd_pos[j] = sb_pos_mem[ifc.sb_rd_addr[j]];
  end

  typedef struct packed {
    logic       slot;
    logic [4:0] s0, s1, d;
    logic       w;
    logic [2:0] lat;
  } ent_t;

  ent_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rdy(input logic [4:0] s);
    return (s == 0) || ((sb_pos_mem[s] >> 1) == 0);
  endfunction

  function automatic bit fwd(input logic [4:0] s);
    return (s != 0) && (sb_pos_mem[s] != 0);
  endfunction

  task automatic offer(input logic [1:0] sv, input int a, input int b, input int c, input int d,
                       input int d0, input int d1, input logic [1:0] w, input int l0, input int l1);
    ifc.in_valid   = 1'b1;
    ifc.in_slot_v  = sv;
    ifc.in_src[0]  = 5'(a); ifc.in_src[1] = 5'(b);
    ifc.in_src[2]  = 5'(c); ifc.in_src[3] = 5'(d);
    ifc.in_dst[0]  = 5'(d0); ifc.in_dst[1] = 5'(d1);
    ifc.in_dst_wen = w;
    ifc.in_lat[0]  = 3'(l0); ifc.in_lat[1] = 3'(l1);
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
  endtask

  // One clock: compare against the model before the edge, then advance it.
  task automatic cycle();
    logic [1:0] ei;
    logic [1:0] ew;
    logic [3:0] ef;
    bit go, all_iss, acc, conflict;
    ent_t h, s, n0, n1;
    ent_t nq[$];
    #1;
    ei = 2'b00; ew = 2'b00; ef = 4'b0000;
    go = ifc.iss_ready && !ifc.flush;
    if (q.size() > 0) begin
      h = q[0];
      if (go && rdy(h.s0) && rdy(h.s1)) ei[h.slot] = 1'b1;
      if (q.size() > 1 && ei[0]) begin
        s = q[1];
        conflict = h.w && (h.d != 0) &&
                   (s.s0 == h.d || s.s1 == h.d || (s.w && s.d == h.d));
        if (!conflict && rdy(s.s0) && rdy(s.s1)) ei[1] = 1'b1;
      end
    end
    if (q.size() == 0)      all_iss = 1;
    else if (q.size() == 1) all_iss = ei[q[0].slot];
    else                    all_iss = (ei == 2'b11);
    acc = ifc.in_valid && !ifc.flush && all_iss;
    foreach (q[k]) begin
      chk("rd_addr_a", ifc.sb_rd_addr[2*q[k].slot], q[k].s0);
      chk("rd_addr_b", ifc.sb_rd_addr[2*q[k].slot+1], q[k].s1);
      if (ei[q[k].slot]) begin
        ew[q[k].slot] = q[k].w && (q[k].d != 0);
        ef[2*q[k].slot]   = fwd(q[k].s0);
        ef[2*q[k].slot+1] = fwd(q[k].s1);
        chk("wr_addr", ifc.sb_wr_addr[q[k].slot], q[k].d);
        chk("wr_pos", ifc.sb_wr_pos[q[k].slot], 8'h01 << q[k].lat);
        chk("iss_dst", ifc.iss_dst[q[k].slot], q[k].d);
        chk("iss_src", {ifc.iss_src[2*q[k].slot], ifc.iss_src[2*q[k].slot+1]}, {q[k].s0, q[k].s1});
      end
    end
    chk("iss_valid", ifc.iss_valid, ei);
    chk("in_ready", ifc.in_ready, all_iss && !ifc.flush);
    chk("wr_ena", ifc.sb_wr_ena, ew);
    chk("iss_fwd", ifc.iss_fwd, ef);
    n0 = '{slot: 1'b0, s0: ifc.in_src[0], s1: ifc.in_src[1], d: ifc.in_dst[0],
           w: ifc.in_dst_wen[0], lat: ifc.in_lat[0]};
    n1 = '{slot: 1'b1, s0: ifc.in_src[2], s1: ifc.in_src[3], d: ifc.in_dst[1],
           w: ifc.in_dst_wen[1], lat: ifc.in_lat[1]};
    @(posedge clk);
    nq = {};
    if (!ifc.flush) begin
      foreach (q[k]) if (!ei[q[k].slot]) nq.push_back(q[k]);
      if (acc && ifc.in_slot_v[0]) begin
        nq = {};
        nq.push_back(n0);
        if (ifc.in_slot_v[1]) nq.push_back(n1);
      end
    end
    q = nq;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_iss_valid"}, ifc.iss_valid, 0);
    chk({tag, "_in_ready"}, ifc.in_ready, 1);
    chk({tag, "_wr_ena"}, ifc.sb_wr_ena, 0);
    chk({tag, "_wr_pos"}, ifc.sb_wr_pos, 0);
    chk({tag, "_wr_addr"}, ifc.sb_wr_addr, 0);
    chk({tag, "_rd_addr"}, ifc.sb_rd_addr, 0);
    chk({tag, "_iss_src"}, ifc.iss_src, 0);
    chk({tag, "_iss_dst"}, ifc.iss_dst, 0);
    chk({tag, "_fwd"}, ifc.iss_fwd, 0);
  endtask

  logic [7:0] pos_tbl [8];

  initial begin
    pos_tbl = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'hFF};
    foreach (sb_pos_mem[r]) sb_pos_mem[r] = 8'h00;
    rst_n = 1'b0;
    ifc.flush = 1'b0; ifc.iss_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_slot_v = '0; ifc.in_src = '0; ifc.in_dst = '0;
    ifc.in_dst_wen = '0; ifc.in_lat = '0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: independent pair issues together one cycle after accept.
    offer(2'b11, 1, 2, 5, 6, 3, 4, 2'b11, 0, 0);
    #1 chk("t1_in_ready", ifc.in_ready, 1);
    cycle(); idle();
    #1 chk("t1_iss", ifc.iss_valid, 2'b11);
    chk("t1_wr_pos", ifc.sb_wr_pos, {8'h01, 8'h01});
    chk("t1_wr_addr", ifc.sb_wr_addr, {5'd4, 5'd3});
    chk("t1_in_ready2", ifc.in_ready, 1);
    cycle();

    // 2: operand too far away stalls, then issues via bypass.
    sb_pos_mem[1] = 8'h04;
    offer(2'b01, 1, 2, 0, 0, 8, 0, 2'b01, 2, 0);
    cycle(); idle();
    #1 chk("t2_stall_iss", ifc.iss_valid, 2'b00);
    chk("t2_stall_rdy", ifc.in_ready, 0);
    cycle();
    sb_pos_mem[1] = 8'h01;
    #1 chk("t2_iss", ifc.iss_valid, 2'b01);
    chk("t2_fwd", ifc.iss_fwd, 4'b0001);
    cycle();
    sb_pos_mem[1] = 8'h00;

    // 3: intra-pair RAW splits the pair; slot1 follows with bypass.
    offer(2'b11, 1, 2, 3, 2, 3, 9, 2'b11, 0, 0);
    cycle(); idle();
    #1 chk("t3_iss0", ifc.iss_valid, 2'b01);
    cycle();
    sb_pos_mem[3] = 8'h01;
    #1 chk("t3_iss1", ifc.iss_valid, 2'b10);
    chk("t3_fwd", ifc.iss_fwd, 4'b0100);
    cycle();
    sb_pos_mem[3] = 8'h00;

    // 4: WAW split, then r0 destinations/sources.
    offer(2'b11, 1, 2, 5, 6, 7, 7, 2'b11, 1, 2);
    cycle(); idle();
    #1 chk("t4_waw0", ifc.iss_valid, 2'b01);
    cycle();
    #1 chk("t4_waw1", ifc.iss_valid, 2'b10);
    cycle();
    sb_pos_mem[0] = 8'hFF;
    offer(2'b11, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0);
    cycle(); idle();
    #1 chk("t4_r0_iss", ifc.iss_valid, 2'b11);
    chk("t4_r0_ena", ifc.sb_wr_ena, 2'b00);
    cycle();
    sb_pos_mem[0] = 8'h00;

    // 5: execute back-pressure, then flush discards the pair.
    offer(2'b11, 1, 2, 5, 6, 10, 11, 2'b11, 0, 0);
    cycle(); idle();
    ifc.iss_ready = 1'b0;
    repeat (3) begin
      #1 chk("t5_stall_iss", ifc.iss_valid, 2'b00);
      chk("t5_stall_rdy", ifc.in_ready, 0);
      cycle();
    end
    ifc.flush = 1'b1;
    #1 chk("t5_fl_iss", ifc.iss_valid, 2'b00);
    chk("t5_fl_ena", ifc.sb_wr_ena, 2'b00);
    chk("t5_fl_rdy", ifc.in_ready, 0);
    cycle();
    ifc.flush = 1'b0; ifc.iss_ready = 1'b1;
    #1 chk("t5_post_rdy", ifc.in_ready, 1);
    chk("t5_post_iss", ifc.iss_valid, 2'b00);
    cycle();

    // 6: async reset while slot1 waits alone.
    offer(2'b11, 1, 2, 3, 2, 3, 9, 2'b11, 0, 0);
    cycle(); idle();
    cycle();
    sb_pos_mem[3] = 8'h04;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("t6_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sb_pos_mem[3] = 8'h00;
    repeat (4) cycle();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 32; r++) sb_pos_mem[r] = pos_tbl[$urandom_range(0, 7)];
      ifc.iss_ready = ($urandom_range(0, 9) < 8);
      ifc.flush     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) != 0)
        offer(($urandom_range(0, 3) == 0) ? 2'b01 : (($urandom_range(0, 9) == 0) ? 2'b00 : 2'b11),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
              $urandom_range(0, 7), $urandom_range(0, 7));
      else
        idle();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
